// File: rtl/enc_sched_pkg.sv
// Shared types and defaults for the encoder sample scheduler.
// Holds the FSM state encoding, the timestamp width and the default parameter values.
package enc_sched_pkg;

   localparam int TS_W             = 16;
   localparam int DEF_N_CH         = 4;
   localparam int DEF_CNT_W        = 5;
   localparam int DEF_UPDATE_RATE  = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SNAP = 2'd2,
      SEND = 2'd3
   } sched_state_e;

endpackage

// File: rtl/enc_period_timer.sv
// Sample-period counter: counts 0..UPDATE_RATE-1 while enabled.
// It emits a registered one-cycle upd_strobe in the cycle where the count is UPDATE_RATE-1.
module enc_period_timer
   import enc_sched_pkg::*;
#(
   parameter int UPDATE_RATE = DEF_UPDATE_RATE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic upd_strobe
);

   localparam int            PW   = (UPDATE_RATE > 1) ? $clog2(UPDATE_RATE) : 1;
   localparam logic [PW-1:0] LAST = PW'(UPDATE_RATE - 1);
   localparam logic [PW-1:0] PRE  = PW'(UPDATE_RATE - 2);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] cnt_r;
   logic          strobe_r;

   // Period count and strobe; the strobe is registered one count early so it lines up with LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         strobe_r <= 1'b0;
      end else if (!enable) begin
         cnt_r    <= '0;
         strobe_r <= 1'b0;
      end else begin
         cnt_r    <= (cnt_r == LAST) ? '0 : cnt_r + ONE;
         strobe_r <= (cnt_r == PRE);
      end
   end

   assign upd_strobe = strobe_r;

endmodule

// File: rtl/encoder_sample_scheduler.sv
// Snapshots N_CH quadrature counts every sample period and streams them out one record per handshake.
// Optional macro ENC_SCHED_TIMESTAMP_EN adds the m_ts output: a frame timestamp latched at SNAP.
module encoder_sample_scheduler
   import enc_sched_pkg::*;
#(
   parameter  int N_CH        = DEF_N_CH,
   parameter  int CNT_W       = DEF_CNT_W,
   parameter  int UPDATE_RATE = DEF_UPDATE_RATE,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [N_CH*CNT_W-1:0] cnt_in,
   output logic                  upd_strobe,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CH_W-1:0]       m_ch,
   output logic [CNT_W-1:0]      m_cnt,
   output logic                  overrun,
   input  logic                  clr_overrun
`ifdef ENC_SCHED_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]       m_ts
`endif
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
   localparam logic [CH_W-1:0] ONE_CH  = CH_W'(1);

   sched_state_e            state_r;
   logic [N_CH*CNT_W-1:0]   shadow_r;
   logic [CH_W-1:0]         ch_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    valid_r;
   logic                    overrun_r;
   logic                    strobe_s;
   logic                    xfer_s;
   logic                    last_s;
   logic                    ovr_set_s;
   logic [CH_W-1:0]         next_ch_s;
   logic [CNT_W-1:0]        next_cnt_s;

   enc_period_timer #(
      .UPDATE_RATE (UPDATE_RATE)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .upd_strobe (strobe_s)
   );

   assign xfer_s    = valid_r & m_ready;
   assign last_s    = (ch_r == LAST_CH);
   assign next_ch_s = ch_r + ONE_CH;
   // A frame is only counted as dropped if records are still outstanding after this cycle's transfer.
   assign ovr_set_s = enable & (state_r == SEND) & strobe_s & ~(xfer_s & last_s);

   // Select the shadowed count of the next channel to present.
   always_comb begin
      next_cnt_s = shadow_r[CNT_W-1:0];
      for (int k = 0; k < N_CH; k++) begin
         next_cnt_s = (next_ch_s == CH_W'(k)) ? shadow_r[k*CNT_W +: CNT_W] : next_cnt_s;
      end
   end

   // Schedule FSM, snapshot registers and output record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         shadow_r <= '0;
         ch_r     <= '0;
         cnt_r    <= '0;
         valid_r  <= 1'b0;
      end else if (!enable) begin
         state_r  <= IDLE;
         ch_r     <= '0;
         valid_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: state_r <= WAIT;
            WAIT: begin
               if (strobe_s) begin
                  state_r <= SNAP;
               end
            end
            SNAP: begin
               state_r  <= SEND;
               shadow_r <= cnt_in;
               ch_r     <= '0;
               cnt_r    <= cnt_in[CNT_W-1:0];
               valid_r  <= 1'b1;
            end
            SEND: begin
               if (strobe_s) begin
                  state_r <= SNAP;
                  valid_r <= 1'b0;
               end else if (xfer_s && last_s) begin
                  state_r <= WAIT;
                  valid_r <= 1'b0;
               end else if (xfer_s) begin
                  ch_r  <= next_ch_s;
                  cnt_r <= next_cnt_s;
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag; a same-cycle set wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (ovr_set_s) begin
         overrun_r <= 1'b1;
      end else if (clr_overrun) begin
         overrun_r <= 1'b0;
      end
   end

   assign upd_strobe = strobe_s;
   assign m_valid    = valid_r;
   assign m_ch       = ch_r;
   assign m_cnt      = cnt_r;
   assign overrun    = overrun_r;

`ifdef ENC_SCHED_TIMESTAMP_EN
   logic [TS_W-1:0] ts_r;
   logic [TS_W-1:0] m_ts_r;

   // Free-running cycle counter, latched once per frame at SNAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_r   <= '0;
         m_ts_r <= '0;
      end else begin
         ts_r <= ts_r + TS_W'(1);
         if (enable && (state_r == SNAP)) begin
            m_ts_r <= ts_r;
         end
      end
   end

   assign m_ts = m_ts_r;
`else
   // Without the timestamp option no cycle counter is built.
`endif

endmodule

// File: doc/encoder_sample_scheduler.md
ENCODER_SAMPLE_SCHEDULER -- requirements
Module: encoder_sample_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of quadrature decoder channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 5, width of each decoder pulse count (two's complement).
REQ-003 SHALL have parameter UPDATE_RATE, default 12, sample period in clk cycles (>=N_CH+2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  run/stop of the sample schedule.
REQ-007 SHALL have port cnt_in  input  N_CH*CNT_W  decoder counts, channel k at bits [k*CNT_W +: CNT_W].
REQ-008 SHALL have port upd_strobe  output  1  one-cycle pulse marking a sample period boundary.
REQ-009 SHALL have port m_valid / m_ready  output / input  1 / 1  output record handshake.
REQ-010 SHALL have port m_ch  output  $clog2(N_CH) (min 1)  channel index of current record.
REQ-011 SHALL have port m_cnt  output  CNT_W  snapshotted count of m_ch.
REQ-012 SHALL have port overrun  output  1  sticky flag: a frame was dropped.
REQ-013 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-014 SHALL run a period counter 0..UPDATE_RATE-1 while enable=1, pulsing upd_strobe for one cycle when it reaches UPDATE_RATE-1, then wrapping to 0.
REQ-015 SHALL hold period counter at 0 and upd_strobe low while enable=0; enable rising starts a full period.
REQ-016 SHALL capture all N_CH counts from cnt_in into shadow registers in the cycle after upd_strobe (SNAP), atomically.
REQ-017 SHALL use FSM states IDLE, WAIT, SNAP, SEND: IDLE->WAIT on enable; WAIT->SNAP on upd_strobe; SNAP->SEND; SEND->WAIT after channel N_CH-1 handshake; any state->IDLE when enable=0 (in-flight frame discarded, m_valid dropped).
REQ-018 SHALL in SEND present channels 0..N_CH-1 in ascending order, one per accepted handshake, m_valid high continuously until last channel accepted.
REQ-019 SHALL keep m_ch and m_cnt stable while m_valid=1 and m_ready=0; a transfer occurs on a cycle with both high.
REQ-020 SHALL, with m_ready held high, deliver one record per cycle: N_CH records in the N_CH cycles following SNAP.
REQ-021 SHALL, if upd_strobe occurs while in SEND, abandon the rest of the current frame after the current record completes, set overrun, and take a new SNAP the cycle after that strobe (m_valid low during SNAP).
REQ-022 SHALL give clr_overrun priority lower than a same-cycle overrun set (flag stays 1).
REQ-023 SHALL pass counts unmodified (no sign extension, no accumulation).

Reset
REQ-024 SHALL on rst_n=0 asynchronously force: FSM IDLE, period counter 0, channel index 0, shadow registers 0, upd_strobe 0, m_valid 0, m_ch 0, m_cnt 0, overrun 0.
REQ-025 SHALL begin operation on the first clk edge after rst_n deasserts, requiring enable=1.

Configuration
REQ-026 SHALL support macro ENC_SCHED_TIMESTAMP_EN: when defined, add output m_ts (16 bits), a free-running cycle counter (reset 0, wraps) latched at SNAP and held identical for all records of that frame; when undefined, port and counter are absent and behaviour is otherwise identical.

Structure
REQ-027 SHALL take the FSM state enum, TS_W=16 constant and default parameter values from shared package enc_sched_pkg.
REQ-028 SHALL place the period counter and strobe generation in sub-module enc_period_timer (ports clk, rst_n, enable, upd_strobe).

Verification
REQ-029 SHALL cover: N_CH=4, UPDATE_RATE=12, enable=1, m_ready=1, cnt_in={3,-1,7,0} -> upd_strobe every 12 cycles; records (0,3),(1,-1),(2,7),(3,0) in 4 consecutive cycles after SNAP.
REQ-030 SHALL cover: m_ready low for 3 cycles on channel 1 -> m_ch=1, m_cnt unchanged for those cycles; frame completes before next strobe; overrun=0.
REQ-031 SHALL cover: m_ready=0 for 20 cycles -> overrun=1 after next strobe, new frame starts at channel 0 with fresh counts; clr_overrun pulse then clears it.
REQ-032 SHALL cover: cnt_in changes in cycle after SNAP -> emitted records show pre-change values.
REQ-033 SHALL cover: enable dropped mid-SEND, and separately rst_n pulsed mid-SEND -> m_valid 0 next cycle (async immediately for reset); restart gives full period before next strobe.
REQ-034 SHALL cover, with ENC_SCHED_TIMESTAMP_EN: m_ts equal across all 4 records of a frame and advancing by 12 between frames.
